// File: rtl/sr_cmd_pkg.sv
// ----------------------------------------------------------------------------
// sr_cmd_pkg
// Shared constants and command encoding for the sr_cmd_debouncer front end.
//   DEBOUNCE_CYCLES_DEF : stable synchronised cycles needed to accept a level
//   REPEAT_CYCLES_DEF   : auto-repeat period (only with SRDB_AUTOREPEAT_EN)
//   CNT_W_DEF           : width of the debounce and repeat counters
//   cmd_e               : one-hot-free 2-bit encoding of the arbitrated command
// ----------------------------------------------------------------------------
package sr_cmd_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_CYCLES_DEF   = 16;
    localparam int CNT_W_DEF           = 8;

    typedef enum logic [1:0] {
        CMD_NONE     = 2'd0,
        CMD_SET      = 2'd1,
        CMD_RESET    = 2'd2,
        CMD_CONFLICT = 2'd3
    } cmd_e;

endpackage

// File: rtl/sr_cmd_debouncer_db_channel.sv
// ----------------------------------------------------------------------------
// db_channel
// One push-button channel: 2-flop synchroniser, debounce counter, stable
// level and a combinational rise-qualify strobe. With SRDB_AUTOREPEAT_EN
// defined it also carries a repeat counter that strobes o_repeat every
// REPEAT_CYCLES cycles while the level is held (and the other channel is not).
// Ports:
//   i_clk         : system clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_raw         : raw button level, asynchronous to i_clk
//   i_other_level : debounced level of the opposite channel (repeat gating)
//   o_level       : debounced (stable) level
//   o_rise        : high in the cycle whose closing edge sets o_level 0->1
//   o_repeat      : high in the cycle whose closing edge is a repeat instant
// ----------------------------------------------------------------------------
module db_channel
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_other_level,
    output logic o_level,
    output logic o_rise,
    output logic o_repeat
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_hit;
    logic             w_fall;

    // The counter only advances while the synchronised input disagrees with
    // the accepted level; any agreement restarts the qualification window.
    assign w_diff  = r_sync2 ^ r_stable;
    assign w_hit   = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_fall  = w_hit & r_stable;
    assign o_rise  = w_hit & ~r_stable;
    assign o_level = r_stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_diff || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_hit) begin
                r_stable <= ~r_stable;
            end
        end
    end

`ifdef SRDB_AUTOREPEAT_EN
    logic [CNT_W-1:0] r_rep;
    logic             w_rep_hit;

    // No repeat on the edge the level is dropping; the counter restarts after
    // every repeat and is parked at zero while the other button is held.
    assign w_rep_hit = r_stable & ~w_fall & ~i_other_level &
                       (r_rep == CNT_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep <= '0;
        end else if (!r_stable || i_other_level || w_fall || w_rep_hit) begin
            r_rep <= '0;
        end else begin
            r_rep <= r_rep + 1'b1;
        end
    end

    assign o_repeat = w_rep_hit;
`else
    localparam int unused_repeat_cycles = REPEAT_CYCLES;
    logic w_unused_other;

    assign w_unused_other = i_other_level;
    assign o_repeat       = 1'b0;
`endif

endmodule

// File: rtl/sr_cmd_debouncer.sv
// ----------------------------------------------------------------------------
// sr_cmd_debouncer
// Turns two raw push-button levels into clean one-cycle s / r pulses for an
// SR flip-flop. s and r are never high together; a simultaneous press is
// reported on conflict instead. Optional auto-repeat: SRDB_AUTOREPEAT_EN.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   set_raw     : raw set request level (asynchronous)
//   reset_raw   : raw reset request level (asynchronous)
//   s, r        : registered one-cycle command pulses
//   conflict    : registered one-cycle strobe, both channels qualified at once
//   set_level   : debounced set level (status)
//   reset_level : debounced reset level (status)
// ----------------------------------------------------------------------------
module sr_cmd_debouncer
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_raw,
    input  logic reset_raw,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_level,
    output logic reset_level
);

    // Channel 0 is set, channel 1 is reset.
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_rise;
    logic [1:0] w_repeat;
    cmd_e       w_cmd;
    logic       r_s;
    logic       r_r;
    logic       r_conflict;

    assign w_raw = {reset_raw, set_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            localparam int OTHER = 1 - gi;
            db_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .REPEAT_CYCLES   (REPEAT_CYCLES)
            ) u_ch (
                .i_clk         (clk),
                .i_rst_n       (rst_n),
                .i_raw         (w_raw[gi]),
                .i_other_level (w_level[OTHER]),
                .o_level       (w_level[gi]),
                .o_rise        (w_rise[gi]),
                .o_repeat      (w_repeat[gi])
            );
        end
    endgenerate

    // A fresh press always wins over a repeat on the other channel, which
    // keeps s and r mutually exclusive even when the two coincide.
    always_comb begin
        w_cmd = CMD_NONE;
        if (w_rise[0] && w_rise[1]) begin
            w_cmd = CMD_CONFLICT;
        end else if (w_rise[0]) begin
            w_cmd = CMD_SET;
        end else if (w_rise[1]) begin
            w_cmd = CMD_RESET;
        end else if (w_repeat[0]) begin
            w_cmd = CMD_SET;
        end else if (w_repeat[1]) begin
            w_cmd = CMD_RESET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s        <= (w_cmd == CMD_SET);
            r_r        <= (w_cmd == CMD_RESET);
            r_conflict <= (w_cmd == CMD_CONFLICT);
        end
    end

    assign s           = r_s;
    assign r           = r_r;
    assign conflict    = r_conflict;
    assign set_level   = w_level[0];
    assign reset_level = w_level[1];

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_sr_cmd_debouncer
// Directed scenarios plus a $urandom phase, checked every cycle against a
// window-based reference model of the debouncer and an SR flip-flop model.
// Honours SRDB_AUTOREPEAT_EN (repeat period 8 when defined).
// ----------------------------------------------------------------------------
module tb_sr_cmd_debouncer;
    import sr_cmd_pkg::*;

    localparam int DEB = DEBOUNCE_CYCLES_DEF;
`ifdef SRDB_AUTOREPEAT_EN
    localparam int REP = 8;
`else
    localparam int REP = REPEAT_CYCLES_DEF;
`endif

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic set_raw   = 1'b0;
    logic reset_raw = 1'b0;
    logic s, r, conflict, set_level, reset_level;

    int   n_err = 0;
    int   n_chk = 0;

    // Reference model state
    bit   hs[$];          // set_raw sampled at each edge since reset
    bit   hr[$];          // reset_raw sampled at each edge since reset
    bit   st[2];          // accepted levels
    int   ref_e[2];       // edge from which the next repeat is timed
    cmd_e exp_cmd;
    bit   q_mdl;
    bit   q_dut;
    int   dut_s_cnt;
    int   dut_s_edge;
    bit   ra, rb;

    always #5 clk = ~clk;

    sr_cmd_debouncer #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CNT_W_DEF),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_raw     (set_raw),
        .reset_raw   (reset_raw),
        .s           (s),
        .r           (r),
        .conflict    (conflict),
        .set_level   (set_level),
        .reset_level (reset_level)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // True when the last DEB synchronised samples (raw delayed two edges) all
    // disagree with the accepted level, i.e. the level changes on this edge.
    function automatic bit win_diff(input bit h[$], input bit cur);
        int e;
        bit v;
        e = h.size() - 1;
        for (int i = e - DEB - 1; i <= e - 2; i++) begin
            v = (i >= 0) ? h[i] : 1'b0;
            if (v == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        hs.delete();
        hr.delete();
        st[0]    = 1'b0;
        st[1]    = 1'b0;
        ref_e[0] = 0;
        ref_e[1] = 0;
        exp_cmd  = CMD_NONE;
        q_mdl    = 1'b0;
        q_dut    = 1'b0;
    endtask

    task automatic model_edge(input bit a, input bit b);
        bit d[2];
        bit rise[2];
        bit fall[2];
        bit rep[2];
        int e;
        hs.push_back(a);
        hr.push_back(b);
        e    = hs.size() - 1;
        d[0] = win_diff(hs, st[0]);
        d[1] = win_diff(hr, st[1]);
        for (int c = 0; c < 2; c++) begin
            rise[c] = d[c] && !st[c];
            fall[c] = d[c] && st[c];
            rep[c]  = 1'b0;
        end
`ifdef SRDB_AUTOREPEAT_EN
        for (int c = 0; c < 2; c++) begin
            rep[c] = st[c] && !fall[c] && !st[1-c] && ((e - ref_e[c]) == REP);
            if (rise[c] || st[1-c] || rep[c]) ref_e[c] = e;
        end
`endif
        if (rise[0] && rise[1])  exp_cmd = CMD_CONFLICT;
        else if (rise[0])        exp_cmd = CMD_SET;
        else if (rise[1])        exp_cmd = CMD_RESET;
        else if (rep[0])         exp_cmd = CMD_SET;
        else if (rep[1])         exp_cmd = CMD_RESET;
        else                     exp_cmd = CMD_NONE;
        for (int c = 0; c < 2; c++) begin
            if (d[c]) st[c] = !st[c];
        end
        if (exp_cmd == CMD_SET)   q_mdl = 1'b1;
        if (exp_cmd == CMD_RESET) q_mdl = 1'b0;
        if (exp_cmd != CMD_NONE)
            $display("edge %0d: expect %s (levels set=%0d reset=%0d)", e, exp_cmd.name(), st[0], st[1]);
    endtask

    task automatic compare_all();
        check("s",           s,           (exp_cmd == CMD_SET));
        check("r",           r,           (exp_cmd == CMD_RESET));
        check("conflict",    conflict,    (exp_cmd == CMD_CONFLICT));
        check("set_level",   set_level,   st[0]);
        check("reset_level", reset_level, st[1]);
        check("s_and_r",     s & r,       1'b0);
        if (s === 1'b1) begin
            q_dut = 1'b1;
            dut_s_cnt++;
            dut_s_edge = hs.size() - 1;
        end else if (r === 1'b1) begin
            q_dut = 1'b0;
        end
        check("ff_q",        q_dut,       q_mdl);
    endtask

    // Entered and left at a falling edge.
    task automatic step(input bit a, input bit b);
        set_raw   = a;
        reset_raw = b;
        @(posedge clk);
        model_edge(a, b);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic steps(input int n, input bit a, input bit b);
        for (int i = 0; i < n; i++) step(a, b);
    endtask

    // Reset is asserted between edges, so the immediate check after #1
    // only passes if the clear is asynchronous.
    task automatic do_reset(input bit a, input bit b);
        rst_n     = 1'b0;
        set_raw   = a;
        reset_raw = b;
        #1;
        model_clear();
        compare_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        dut_s_cnt  = 0;
        dut_s_edge = -1;
        @(negedge clk);

        // Reset exit with set held: single s pulse after edge DEB+1
        do_reset(1'b1, 1'b0);
        dut_s_cnt = 0;
        steps(12, 1'b1, 1'b0);
        check("rst_exit_s_count", dut_s_cnt[7:0], 8'd1);
        check("rst_exit_s_edge",  dut_s_edge[7:0], 8'(DEB + 1));
        steps(10, 1'b0, 1'b0);

        // Glitches of 2 and 3 cycles are rejected; 4 cycles is accepted
        for (int len = 2; len <= 4; len++) begin
            steps(len, 1'b1, 1'b0);
            steps(10,  1'b0, 1'b0);
        end
        steps(3,  1'b0, 1'b1);
        steps(10, 1'b0, 1'b0);

        // Long reset press: one r pulse, level held until release debounces
        steps(40, 1'b0, 1'b1);
        steps(12, 1'b0, 1'b0);

        // Simultaneous press: conflict only
        steps(12, 1'b1, 1'b1);
        steps(12, 1'b0, 1'b0);

        // Set held, reset joins 10 cycles later: q goes 0->1->0
        steps(10, 1'b1, 1'b0);
        steps(20, 1'b1, 1'b1);
        steps(12, 1'b0, 1'b0);

        // Long set hold (repeats when enabled), then reset stops them
        steps(40, 1'b1, 1'b0);
        steps(20, 1'b1, 1'b1);
        steps(12, 1'b0, 1'b0);

        // Asynchronous reset while set_level is high
        steps(10, 1'b1, 1'b0);
        do_reset(1'b0, 1'b0);

        // Random slowly-toggling buttons
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ra = ~ra;
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            step(ra, rb);
        end
        steps(12, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_cmd_debouncer.md
Name: sr_cmd_debouncer

Overview:
Front-end stage that feeds sr_flip_flop. It takes two raw, asynchronous push-button levels (set request, reset request) and produces clean single-cycle s/r command pulses.
- Each raw input is synchronised and debounced before use.
- s and r are guaranteed never to be high in the same cycle, so the flip-flop never sees the forbidden S=R=1 input.
- A simultaneous request is reported on a conflict strobe instead of being forwarded.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a level change (legal range 2..255).
CNT_W, 8, width of the debounce and repeat counters; must satisfy 2**CNT_W > max(DEBOUNCE_CYCLES, REPEAT_CYCLES).
REPEAT_CYCLES, 16, auto-repeat period in cycles; used only when SRDB_AUTOREPEAT_EN is defined.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
set_raw  input  1  raw set-request level, asynchronous to clk
reset_raw  input  1  raw reset-request level, asynchronous to clk
s  output  1  one-cycle set pulse, drives sr_flip_flop.s
r  output  1  one-cycle reset pulse, drives sr_flip_flop.r
conflict  output  1  one-cycle strobe: both channels qualified in the same cycle
set_level  output  1  debounced set level, for status only
reset_level  output  1  debounced reset level, for status only

Behaviour:
- Reset (rst_n=0, asynchronous) clears all state: synchroniser flops, counters, stable levels, s, r, conflict, set_level, reset_level. Outputs go to 0 immediately on assertion. Operation resumes at the first rising clk edge after deassertion.
- Per channel, raw input passes through a 2-flop synchroniser giving sync.
- Per-channel counter cnt behaviour:
  - cnt <= 0 whenever sync == stable.
  - Otherwise cnt increments each cycle.
  - When cnt == DEBOUNCE_CYCLES-1 and sync != stable: stable toggles on that edge and cnt <= 0.
- Qualify event: stable transitions 0->1 on an edge. The 1->0 transition produces no pulse.
- Output rules, all registered and decided on the same edge as the qualify:
  - set qualifies alone -> s=1 for one cycle.
  - reset qualifies alone -> r=1 for one cycle.
  - Both qualify on the same edge -> s=0, r=0, conflict=1 for one cycle. Both stable levels still update.
- Latency: raw rising first sampled at edge k and held -> pulse high in the cycle after edge k+DEBOUNCE_CYCLES+1 (k+5 for the default).
- Glitch rejection: a sync excursion shorter than DEBOUNCE_CYCLES cycles clears cnt and produces no pulse and no level change.
- Holding a raw input high yields exactly one pulse; release must also debounce before another press is recognised.
- One channel held high while the other qualifies: the other channel pulses normally, with no conflict.
- Invariant: s & r == 0 in every cycle, including reset exit and the auto-repeat cases below.

Optional Feature:
SRDB_AUTOREPEAT_EN
- Defined: while a channel's stable level is 1, a per-channel repeat counter runs and a further pulse on that channel is emitted every REPEAT_CYCLES cycles after the initial pulse.
  - Repeats are suppressed, and the repeat counter held at 0, while the other channel's stable level is 1.
  - The repeat counter clears when stable falls.
  - Repeat pulses never raise conflict.
- Not defined: no repeat logic; exactly one pulse per qualified press.

Decomposition:
- Package sr_cmd_pkg holds:
  - default constants DEBOUNCE_CYCLES_DEF=4 and REPEAT_CYCLES_DEF=16;
  - CNT_W_DEF=8;
  - a 2-bit command encoding (CMD_NONE=0, CMD_SET=1, CMD_RESET=2, CMD_CONFLICT=3), used internally and by the bench scoreboard.
- Sub-module db_channel: synchroniser, debounce counter, stable level and rise-qualify output, plus the repeat counter when SRDB_AUTOREPEAT_EN is defined. It is instantiated twice; the top level does arbitration and output registers only.

Test Plan:
- Reset with set_raw=1 held, release rst_n at edge 0 -> outputs 0 during reset; s pulses exactly once, in the cycle after edge 5 (defaults); r=0 throughout.
- set_raw glitch high for 2 cycles, then low -> s, r, conflict, set_level stay 0; cnt returns to 0.
- reset_raw held 40 cycles (macro undefined) -> exactly one r pulse at the expected latency; reset_level=1 until the release debounces.
- set_raw and reset_raw rise on the same edge -> conflict=1 for one cycle; s=r=0 throughout; both levels =1.
- set_raw held, then reset_raw rises 10 cycles later -> one s pulse, then one r pulse, never overlapping, conflict=0; the bench model of sr_flip_flop shows q 0->1->0.
- SRDB_AUTOREPEAT_EN defined, REPEAT_CYCLES=8, set_raw held 40 cycles -> s pulses at the initial latency, then every 8 cycles; asserting reset_raw stops further s repeats.
